// File: rtl/reel_spin_seq.sv
// reel_spin_seq: frame-timed N-reel sprite sequencer that stops reels strictly in order on latched targets
// Ports:
//   clk, reset      - pixel clock; asynchronous active-high reset
//   vsync           - VGA vertical sync (active-low); its falling edge is the frame tick
//   start_spin      - level spin request, rising edge accepted only in IDLE
//   final_sprites   - packed per-reel targets, reel k at [k*IDX_W +: IDX_W]
//   quick_stop      - only when REEL_SPIN_SEQ_QUICK_STOP_EN is defined: stop all reels on a tick
//   sprite_idx      - packed per-reel current sprite index
//   reel_stopped    - per-reel stationary flag
//   busy, done      - high in SPIN; one-cycle completion pulse in DONE
//   state           - IDLE=0, SPIN=1, DONE=2
// Optional feature macro: REEL_SPIN_SEQ_QUICK_STOP_EN
module reel_spin_seq #(
    parameter int NUM_REELS      = 3,
    parameter int NUM_SPRITES    = 7,
    parameter int SPIN_FRAMES    = 4,
    parameter int STAGGER_FRAMES = 2,
    parameter int STEP_FRAMES    = 1,
    localparam int IDX_W         = $clog2(NUM_SPRITES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vsync,
    input  logic                       start_spin,
    input  logic [NUM_REELS*IDX_W-1:0] final_sprites,
`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
    input  logic                       quick_stop,
`endif
    output logic [NUM_REELS*IDX_W-1:0] sprite_idx,
    output logic [NUM_REELS-1:0]       reel_stopped,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 state
);
    localparam int FC_MAX = SPIN_FRAMES + (NUM_REELS - 1) * STAGGER_FRAMES + NUM_SPRITES * STEP_FRAMES + 1;
    localparam int FC_W = $clog2(FC_MAX + 1);
    localparam int SC_W = $clog2(STEP_FRAMES + 1);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_FRAMES);
    typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1, DONE = 2'd2} state_t;
    state_t state_q, state_d;
    logic vsync_q, start_q, busy_q, done_q, tick, start_edge, qs;
    logic [FC_W-1:0] frame_q, frame_d;
    logic [NUM_REELS-1:0] stopped_q, stopped_d, pred;
    logic [IDX_W-1:0] idx_q [NUM_REELS];
    logic [IDX_W-1:0] idx_d [NUM_REELS];
    logic [IDX_W-1:0] tgt_q [NUM_REELS];
    logic [IDX_W-1:0] tgt_d [NUM_REELS];
    logic [IDX_W-1:0] raw [NUM_REELS];
    logic [SC_W-1:0] step_q [NUM_REELS];
    logic [SC_W-1:0] step_d [NUM_REELS];
    // vsync_q resets to 0, so no tick can fire on the first cycle after reset
    assign tick = vsync_q & ~vsync;
    assign start_edge = ~start_q & start_spin;
`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
    assign qs = quick_stop;
`else
    assign qs = 1'b0;
`endif
    // reel k may only stop once reel k-1 is already stopped; reel 0 has no predecessor
    assign pred = NUM_REELS'({stopped_q, 1'b1});
    genvar i;
    for (i = 0; i < NUM_REELS; i++) begin : g_reel
        assign raw[i] = final_sprites[i*IDX_W +: IDX_W];
        assign sprite_idx[i*IDX_W +: IDX_W] = idx_q[i];
    end
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        stopped_d = stopped_q;
        idx_d = idx_q;
        tgt_d = tgt_q;
        step_d = step_q;
        case (state_q)
            IDLE: if (start_edge) begin
                state_d = SPIN;
                frame_d = '0;
                stopped_d = '0;
                for (int k = 0; k < NUM_REELS; k++) begin
                    tgt_d[k] = raw[k] > MAX_IDX ? MAX_IDX : raw[k];
                    step_d[k] = '0;
                end
            end
            SPIN: if (&stopped_q) state_d = DONE;
            else if (tick) begin
                frame_d = &frame_q ? frame_q : frame_q + 1'b1;
                for (int k = 0; k < NUM_REELS; k++) begin
                    if (!stopped_q[k]) begin
                        if (qs) begin
                            idx_d[k] = tgt_q[k];
                            stopped_d[k] = 1'b1;
                        end else if (frame_q >= FC_W'(SPIN_FRAMES + k * STAGGER_FRAMES) && pred[k] && idx_q[k] == tgt_q[k]) begin
                            stopped_d[k] = 1'b1;
                        end else if (step_q[k] + 1'b1 == STEP_LAST) begin
                            idx_d[k] = idx_q[k] == MAX_IDX ? '0 : idx_q[k] + 1'b1;
                            step_d[k] = '0;
                        end else begin
                            step_d[k] = step_q[k] + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            start_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            frame_q <= '0;
            stopped_q <= '1;
            idx_q <= '{default: '0};
            tgt_q <= '{default: '0};
            step_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            start_q <= start_spin;
            busy_q <= state_d == SPIN;
            done_q <= state_d == DONE;
            frame_q <= frame_d;
            stopped_q <= stopped_d;
            idx_q <= idx_d;
            tgt_q <= tgt_d;
            step_q <= step_d;
        end
    end
    assign reel_stopped = stopped_q;
    assign busy = busy_q;
    assign done = done_q;
    assign state = state_q;
endmodule

// File: tb/tb_reel_spin_seq.sv
// tb_reel_spin_seq: scoreboard bench for reel_spin_seq with default parameters
module tb_reel_spin_seq;
    logic clk = 1'b0;
    logic reset, vsync, start_spin, busy, done;
    logic [8:0] final_sprites, sprite_idx;
    logic [2:0] reel_stopped;
    logic [1:0] state;
`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
    logic quick_stop;
`endif
    always #5 clk = ~clk;

    reel_spin_seq dut (
        .clk(clk),
        .reset(reset),
        .vsync(vsync),
        .start_spin(start_spin),
        .final_sprites(final_sprites),
`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
        .quick_stop(quick_stop),
`endif
        .sprite_idx(sprite_idx),
        .reel_stopped(reel_stopped),
        .busy(busy),
        .done(done),
        .state(state)
    );

    typedef struct {int reel; int tick; int idx;} stop_t;
    stop_t sq[$];
    int dq[$];
    int checks = 0, errors = 0, tick_no = 0, cyc = 0, last_stop_cyc = 0;
    logic [2:0] prev_stop;
    logic [1:0] prev_state;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pack(input int r2, input int r1, input int r0);
        return (r2 << 6) | (r1 << 3) | r0;
    endfunction

    task automatic exp_stop(input int r, input int t, input int i);
        stop_t s;
        s.reel = r; s.tick = t; s.idx = i;
        sq.push_back(s);
    endtask

    // monitor: pops an expected stop whenever a reel_stopped bit rises, an expected result on done
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            prev_stop = reel_stopped;
            prev_state = state;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (reel_stopped[k] && !prev_stop[k]) begin
                    last_stop_cyc = cyc;
                    if (sq.size() == 0) chk("unexpected_stop", k, 99);
                    else begin
                        stop_t s;
                        s = sq.pop_front();
                        chk("stop_reel_order", k, s.reel);
                        chk("stop_tick", tick_no, s.tick);
                        chk("stop_idx", sprite_idx[k*3 +: 3], s.idx);
                    end
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    chk("done_idx", sprite_idx, dq.pop_front());
                    chk("done_all_stopped", reel_stopped, 3'b111);
                    chk("done_gap", cyc - last_stop_cyc, 1);
                end
            end
            if (state != prev_state)
                chk("state_trans", {prev_state, state, busy, done},
                    {prev_state, prev_state == 2'd2 ? 2'd0 : prev_state + 2'd1, state == 2'd1 ? 1'b1 : 1'b0, state == 2'd2 ? 1'b1 : 1'b0});
            prev_stop = reel_stopped;
            prev_state = state;
        end
    end

    task automatic start(input logic [8:0] tgt);
        @(posedge clk); #1;
        start_spin = 1'b1;
        final_sprites = tgt;
        tick_no = 0;
        @(posedge clk); #1;
    endtask

    task automatic frames(input int n, input int qs_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            vsync = 1'b0;
            tick_no++;
`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
            quick_stop = (tick_no == qs_at);
`else
            if (qs_at < 0) $display("unused quick-stop tick %0d", qs_at);
`endif
            @(posedge clk); #1;
            vsync = 1'b1;
`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
            quick_stop = 1'b0;
`endif
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic run();
        int n = 0;
        while ((sq.size() > 0 || dq.size() > 0) && n < 40) begin
            frames(1, 0);
            n++;
        end
        chk("drain_pending", sq.size() + dq.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        vsync = 1'b1;
        start_spin = 1'b0;
        final_sprites = '0;
`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
        quick_stop = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_idx", sprite_idx, 0);
        chk("rst_stopped", reel_stopped, 3'b111);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // all targets 0 from index 0: stops on ticks 8, 15, 22
        start(9'd0);
        start_spin = 1'b0;
        chk("spin_state", state, 1);
        chk("spin_busy", busy, 1);
        exp_stop(0, 8, 0); exp_stop(1, 15, 0); exp_stop(2, 22, 0);
        dq.push_back(0);
        run();

        // targets {6,3,5}; targets changed after latch must be ignored
        start(9'(pack(6, 3, 5)));
        start_spin = 1'b0;
        final_sprites = 9'h1ff;
        exp_stop(0, 6, 5); exp_stop(1, 11, 3); exp_stop(2, 14, 6);
        dq.push_back(pack(6, 3, 5));
        run();

        // reel 0 target 7 clamps to 6
        start(9'(pack(1, 0, 7)));
        start_spin = 1'b0;
        exp_stop(0, 9, 6); exp_stop(1, 12, 0); exp_stop(2, 17, 1);
        dq.push_back(pack(1, 0, 6));
        run();

        // start held high, then re-pulsed mid-spin: still one spin, one done
        start(9'(pack(3, 3, 3)));
        exp_stop(0, 5, 3); exp_stop(1, 11, 3); exp_stop(2, 17, 3);
        dq.push_back(pack(3, 3, 3));
        frames(3, 0);
        start_spin = 1'b0;
        @(posedge clk); #1;
        start_spin = 1'b1;
        run();
        frames(3, 0);
        chk("held_start_idle", state, 0);
        chk("held_start_busy", busy, 0);
        start_spin = 1'b0;

        // reset mid-spin after reels 0 and 1 stopped
        start(9'd0);
        start_spin = 1'b0;
        exp_stop(0, 5, 0); exp_stop(1, 12, 0);
        frames(12, 0);
        chk("pre_reset_stops", sq.size(), 0);
        chk("pre_reset_stopped", reel_stopped, 3'b011);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_stopped", reel_stopped, 3'b111);
        chk("mid_rst_idx", sprite_idx, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_state", state, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        frames(3, 0);
        chk("post_rst_state", state, 0);
        chk("post_rst_stopped", reel_stopped, 3'b111);

`ifdef REEL_SPIN_SEQ_QUICK_STOP_EN
        // quick stop on tick 2: all reels land on targets at once
        start(9'(pack(1, 2, 3)));
        start_spin = 1'b0;
        exp_stop(0, 2, 3); exp_stop(1, 2, 2); exp_stop(2, 2, 1);
        dq.push_back(pack(1, 2, 3));
        frames(2, 2);
        run();
`endif

        frames(2, 0);
        chk("final_queues", sq.size() + dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
